// File: rtl/udma_spis_stream.sv
// SPI/QSPI target endpoint. SCK/CSN/SD are oversampled in the system clock domain.
// Bytes are exchanged with the uDMA over valid/ready streams. The SPI link runs in mode 0, MSB first.
module udma_spis_stream #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       sys_clk_i,
  input  logic       rstn_i,
  input  logic       cfg_en_i,
  input  logic       cfg_quad_i,
  input  logic       cfg_qtx_i,
  input  logic       spi_sck_i,
  input  logic       spi_csn_i,
  input  logic [3:0] spi_sdi_i,
  output logic [3:0] spi_sdo_o,
  output logic [3:0] spi_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       rx_overflow_o,
  output logic       tx_underrun_o,
  output logic       eot_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  // synchronizers; CSN resets high so leaving reset never looks like a select
  logic [SYNC_STAGES-1:0]      sck_sync, csn_sync;
  logic [SYNC_STAGES-1:0][3:0] sdi_sync;
  logic                        sck_s, csn_s, sck_d, csn_d;
  logic [3:0]                  sdi_s;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sck_sync <= '0;
      csn_sync <= '1;
      sdi_sync <= '0;
      sck_d    <= 1'b0;
      csn_d    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
      sck_d    <= sck_s;
      csn_d    <= csn_s;
    end
  end

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign csn_s = csn_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  logic sck_rise, sck_fall, csn_fall;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csn_fall = ~csn_s & csn_d;

  logic       quad_q, qtx_q;
  logic [7:0] tx_sr, rx_sr, hold_q;
  logic [2:0] tx_cnt, rx_cnt;
  logic       hold_full;

  logic       start, stop, run, tx_en, rx_en, tx_en_start;
  logic [2:0] last_cnt;
  logic       tx_step, tx_reload, tx_take, tx_write, hold_take, underrun;
  logic       rx_step, rx_done, rx_accept;
  logic [7:0] rx_shift, tx_load_val;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_en_i && csn_fall) state_nxt = ACTIVE;
      ACTIVE:  if (csn_s || !cfg_en_i)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  assign start       = (state == IDLE) && cfg_en_i && csn_fall;
  assign stop        = (state == ACTIVE) && (csn_s || !cfg_en_i);
  assign run         = (state == ACTIVE) && !stop;
  assign tx_en       = !quad_q || qtx_q;
  assign rx_en       = !quad_q || !qtx_q;
  assign tx_en_start = !cfg_quad_i || cfg_qtx_i;
  assign last_cnt    = quad_q ? 3'd1 : 3'd7;

  // TX: a "take" empties the holding register into the shifter, or substitutes IDLE_BYTE
  assign tx_step     = run && tx_en && sck_fall;
  assign tx_reload   = tx_step && (tx_cnt == last_cnt);
  assign tx_take     = start ? tx_en_start : tx_reload;
  assign tx_write    = tx_valid_i && tx_ready_o;
  assign hold_take   = tx_take && hold_full;
  assign underrun    = tx_take && !hold_full;
  assign tx_load_val = hold_full ? hold_q : IDLE_BYTE;

  // RX is off while quad transmit owns all four lines
  assign rx_step   = run && rx_en && sck_rise;
  assign rx_shift  = quad_q ? {rx_sr[3:0], sdi_s} : {rx_sr[6:0], sdi_s[0]};
  assign rx_done   = rx_step && (rx_cnt == last_cnt);
  assign rx_accept = rx_done && (!rx_valid_o || rx_ready_i);

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      quad_q <= 1'b0;
      qtx_q  <= 1'b0;
      tx_sr  <= '0;
      tx_cnt <= '0;
    end else if (start) begin
      quad_q <= cfg_quad_i;
      qtx_q  <= cfg_qtx_i;
      tx_cnt <= '0;
      if (tx_en_start) tx_sr <= tx_load_val;
    end else if (stop) begin
      tx_sr  <= '0;
      tx_cnt <= '0;
    end else if (tx_reload) begin
      tx_sr  <= tx_load_val;
      tx_cnt <= '0;
    end else if (tx_step) begin
      tx_sr  <= quad_q ? {tx_sr[3:0], 4'b0} : {tx_sr[6:0], 1'b0};
      tx_cnt <= tx_cnt + 3'd1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else begin
      if (tx_write) hold_q <= tx_data_i;
      // a write landing on a reload cycle wins: the register stays full
      if (tx_write)       hold_full <= 1'b1;
      else if (hold_take) hold_full <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_sr  <= '0;
      rx_cnt <= '0;
    end else if (start || stop) begin
      rx_sr  <= '0;
      rx_cnt <= '0;
    end else if (rx_step) begin
      rx_sr  <= rx_shift;
      rx_cnt <= rx_done ? 3'd0 : rx_cnt + 3'd1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      rx_overflow_o <= 1'b0;
      tx_underrun_o <= 1'b0;
      eot_o         <= 1'b0;
    end else begin
      if (rx_accept) begin
        rx_data_o  <= rx_shift;
        rx_valid_o <= 1'b1;
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      rx_overflow_o <= rx_done && !rx_accept;
      tx_underrun_o <= underrun;
      eot_o         <= (state == ACTIVE) && csn_s;
    end
  end

  assign tx_ready_o = !hold_full;

  // pads released combinationally on the cycle the frame ends
  always_comb begin
    spi_sdo_o = '0;
    spi_oe_o  = '0;
    if (run) begin
      if (!quad_q) begin
        spi_oe_o     = 4'b0010;
        spi_sdo_o[1] = tx_sr[7];
      end else if (qtx_q) begin
        spi_oe_o  = 4'b1111;
        spi_sdo_o = tx_sr[7:4];
      end
    end
  end

endmodule

// File: tb/tb_udma_spis_stream.sv
// Directed bench for udma_spis_stream: a behavioural SPI master drives frames, received
// bytes are checked against a scoreboard queue, pulses are counted by a monitor.
module tb_udma_spis_stream;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cfg_en = 1'b1, cfg_quad = 1'b0, cfg_qtx = 1'b0;
  logic       sck = 1'b0, csn = 1'b1;
  logic [3:0] sdi = '0;
  logic [3:0] sdo, oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0, tx_ready;
  logic       rx_ovf, tx_und, eot;

  int n_pass = 0, n_fail = 0;
  int n_rx = 0, n_ovf = 0, n_und = 0, n_eot = 0;
  logic [7:0] sb[$];

  udma_spis_stream #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .sys_clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .cfg_quad_i(cfg_quad),
    .cfg_qtx_i(cfg_qtx), .spi_sck_i(sck), .spi_csn_i(csn), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo), .spi_oe_o(oe), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_overflow_o(rx_ovf), .tx_underrun_o(tx_und), .eot_o(eot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor: handshakes pop the scoreboard, pulses are counted
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      n_rx++;
      if (sb.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
      else check("rx_byte", {24'd0, rx_data}, {24'd0, sb.pop_front()});
    end
    if (rx_ovf) n_ovf++;
    if (tx_und) n_und++;
    if (eot)    n_eot++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    csn = 1'b0;
    cyc(HALF);
  endtask

  task automatic frame_end();
    cyc(HALF);
    csn = 1'b1;
    cyc(2 * HALF);
  endtask

  // single mode: MISO is sampled just before each rising edge, as a master would
  task automatic spi_bits(input logic [7:0] mosi, input int nb,
                          output logic [7:0] miso, output logic [3:0] oe_or);
    miso = '0;
    oe_or = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      sdi = {3'b000, mosi[i]};
      cyc(HALF);
      miso[i] = sdo[1];
      oe_or |= oe;
      sck = 1'b1;
      cyc(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic quad_byte(input logic [7:0] mosi, output logic [7:0] miso,
                           output logic [3:0] oe_or, output logic [3:0] oe_and);
    miso = '0;
    oe_or = '0;
    oe_and = '1;
    for (int i = 1; i >= 0; i--) begin
      sdi = mosi[i*4 +: 4];
      cyc(HALF);
      miso[i*4 +: 4] = sdo;
      oe_or |= oe;
      oe_and &= oe;
      sck = 1'b1;
      cyc(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    check("tx_ready_after_write", {31'd0, tx_ready}, 32'd0);
  endtask

  initial begin
    logic [7:0] m1, m2;
    logic [3:0] oor, oand;
    int s_und, s_eot, s_rx, s_ovf;

    cyc(4);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_oe", {28'd0, oe}, 32'd0);
    check("rst_sdo", {28'd0, sdo}, 32'd0);
    rstn = 1'b1;
    cyc(4);

    // 1: single full duplex, one queued TX byte then underrun
    tx_push(8'h5A);
    s_und = n_und; s_eot = n_eot; s_rx = n_rx;
    frame_start();
    check("t1_oe_single", {28'd0, oe}, 32'h2);
    sb.push_back(8'hA5); spi_bits(8'hA5, 8, m1, oor);
    sb.push_back(8'h3C); spi_bits(8'h3C, 8, m2, oor);
    // counted before the closing fall of byte 2 requests yet another byte
    check("t1_underrun_cnt", n_und - s_und, 1);
    check("t1_miso_b0", {24'd0, m1}, 32'h5A);
    check("t1_miso_b1", {24'd0, m2}, 32'hFF);
    frame_end();
    check("t1_eot", n_eot - s_eot, 1);
    check("t1_rx_cnt", n_rx - s_rx, 2);
    check("t1_oe_idle", {28'd0, oe}, 32'd0);

    // 2a: quad receive
    cfg_quad = 1'b1; cfg_qtx = 1'b0; s_rx = n_rx;
    frame_start();
    sb.push_back(8'h12); quad_byte(8'h12, m1, oor, oand);
    check("t2_oe_rx_a", {28'd0, oor}, 32'd0);
    sb.push_back(8'h34); quad_byte(8'h34, m1, oor, oand);
    check("t2_oe_rx_b", {28'd0, oor}, 32'd0);
    frame_end();
    check("t2_rx_cnt", n_rx - s_rx, 2);

    // 2b: quad transmit
    tx_push(8'hC3);
    cfg_qtx = 1'b1; s_rx = n_rx;
    frame_start();
    quad_byte(8'h00, m1, oor, oand);
    check("t2_qtx_data", {24'd0, m1}, 32'hC3);
    check("t2_qtx_oe", {28'd0, oand}, 32'hF);
    frame_end();
    check("t2_qtx_no_rx", n_rx - s_rx, 0);
    check("t2_qtx_valid", {31'd0, rx_valid}, 32'd0);
    cfg_quad = 1'b0; cfg_qtx = 1'b0;

    // 3: overflow with consumer stalled
    rx_ready = 1'b0; s_ovf = n_ovf;
    frame_start();
    sb.push_back(8'h01); spi_bits(8'h01, 8, m1, oor);
    spi_bits(8'h02, 8, m1, oor);
    spi_bits(8'h03, 8, m1, oor);
    frame_end();
    check("t3_valid_held", {31'd0, rx_valid}, 32'd1);
    check("t3_data_held", {24'd0, rx_data}, 32'h01);
    check("t3_ovf_cnt", n_ovf - s_ovf, 2);
    rx_ready = 1'b1;
    cyc(3);
    check("t3_valid_clear", {31'd0, rx_valid}, 32'd0);
    check("t3_sb_empty", sb.size(), 0);

    // 4: frame aborted after 5 bits, then a clean one
    s_rx = n_rx; s_eot = n_eot;
    frame_start();
    spi_bits(8'hF0, 5, m1, oor);
    frame_end();
    check("t4_no_rx", n_rx - s_rx, 0);
    check("t4_eot", n_eot - s_eot, 1);
    frame_start();
    sb.push_back(8'h81); spi_bits(8'h81, 8, m1, oor);
    frame_end();
    check("t4_rx_81", n_rx - s_rx, 1);

    // 5: async reset in mid-byte
    s_eot = n_eot; s_rx = n_rx;
    frame_start();
    spi_bits(8'hAA, 4, m1, oor);
    rstn = 1'b0;
    #1;
    check("t5_rst_oe", {28'd0, oe}, 32'd0);
    check("t5_rst_data", {24'd0, rx_data}, 32'd0);
    check("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("t5_rst_ready", {31'd0, tx_ready}, 32'd1);
    csn = 1'b1;
    cyc(4);
    rstn = 1'b1;
    cyc(4);
    check("t5_no_eot", n_eot - s_eot, 0);
    frame_start();
    sb.push_back(8'h7E); spi_bits(8'h7E, 8, m1, oor);
    frame_end();
    check("t5_rx_7e", n_rx - s_rx, 1);

    // 6: disabled, then enabled mid-frame
    cfg_en = 1'b0; s_rx = n_rx; s_eot = n_eot;
    frame_start();
    spi_bits(8'h55, 8, m1, oor);
    check("t6_dis_oe", {28'd0, oor}, 32'd0);
    cfg_en = 1'b1;
    spi_bits(8'h66, 8, m1, oor);
    check("t6_mid_oe", {28'd0, oor}, 32'd0);
    frame_end();
    check("t6_no_rx", n_rx - s_rx, 0);
    check("t6_no_eot", n_eot - s_eot, 0);
    frame_start();
    sb.push_back(8'h99); spi_bits(8'h99, 8, m1, oor);
    frame_end();
    check("t6_rx_99", n_rx - s_rx, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
